// File: rtl/match_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : match_collector_pkg
// Brief    : Shared state encoding and counter widths for the match collector
// Revision : 1.0 - initial release
// ============================================================================
package match_collector_pkg;

    localparam int DROP_W = 16;
    localparam int MPKT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/match_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : match_collector_if
// Brief    : Valid/ready alert stream from the collector to the formatter
// Revision : 1.0 - initial release
// ============================================================================
interface match_collector_if #(
    parameter int ID_W     = 6,
    parameter int PKT_ID_W = 16
);
    logic                alert_valid;
    logic                alert_ready;
    logic [ID_W-1:0]     alert_engine_id;
    logic [PKT_ID_W-1:0] alert_pkt_id;
    logic                alert_last;

    modport master (
        output alert_valid,
        output alert_engine_id,
        output alert_pkt_id,
        output alert_last,
        input  alert_ready
    );

    modport slave (
        input  alert_valid,
        input  alert_engine_id,
        input  alert_pkt_id,
        input  alert_last,
        output alert_ready
    );
endinterface
`default_nettype wire

// File: rtl/match_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : match_prio_enc
// Brief    : Lowest-set-bit priority encoder with any-set / single-set flags
// Revision : 1.0 - initial release
// ============================================================================
module match_prio_enc #(
    parameter int NUM_ENGINES = 64,
    parameter int ID_W        = 6
) (
    input  wire logic [NUM_ENGINES-1:0] i_vec,
    output logic      [ID_W-1:0]        o_idx,
    output logic                        o_any,
    output logic                        o_single
);

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    logic [NUM_ENGINES-1:0] w_rest;
    assign w_rest = i_vec & (i_vec - NUM_ENGINES'(1));

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

    assign o_any    = |i_vec;
    assign o_single = o_any && (w_rest == '0);

endmodule
`default_nettype wire

// File: rtl/match_collector.sv
`default_nettype none
// ============================================================================
// Module   : match_collector
// Brief    : Snapshots sticky engine match lines after end-of-data and
//            serialises matching engine indices, lowest first, as alerts
// Revision : 1.0 - initial release
// ============================================================================
module match_collector
    import match_collector_pkg::*;
#(
    parameter int NUM_ENGINES = 64,
    parameter int ID_W        = 6,
    parameter int PKT_ID_W    = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   en,
    input  wire logic                   eod,
    input  wire logic [PKT_ID_W-1:0]    pkt_id_in,
    input  wire logic [NUM_ENGINES-1:0] match_in,
    match_collector_if.master           alert,
    output logic                        busy,
    output logic [DROP_W-1:0]           drop_cnt,
    output logic [MPKT_W-1:0]           match_pkt_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_ENGINES-1:0] r_vec;
    logic [PKT_ID_W-1:0]    r_pkt_id;
    logic [ID_W-1:0]        w_low_idx;
    logic                   w_any;
    logic                   w_single;
    logic                   w_eod;
    logic                   w_fire;

    match_prio_enc #(
        .NUM_ENGINES (NUM_ENGINES),
        .ID_W        (ID_W)
    ) u_prio_enc (
        .i_vec    (r_vec),
        .o_idx    (w_low_idx),
        .o_any    (w_any),
        .o_single (w_single)
    );

    assign w_eod  = en && eod;
    assign w_fire = (r_state == EMIT) && alert.alert_ready;

    // Alert fields derive only from registered state, so they hold while stalled.
    assign alert.alert_valid     = (r_state == EMIT);
    assign alert.alert_engine_id = w_low_idx;
    assign alert.alert_pkt_id    = r_pkt_id;
    assign alert.alert_last      = w_single;
    assign busy                  = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one capture cycle, then emit until the vector drains.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_eod) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = (match_in != '0) ? EMIT : IDLE;
            end
            EMIT: begin
                if (w_fire && w_single) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot vector, packet tag and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec         <= '0;
            r_pkt_id      <= '0;
            drop_cnt      <= '0;
            match_pkt_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_eod) begin
                r_pkt_id <= pkt_id_in;
            end
            if (r_state == CAPTURE) begin
                r_vec <= match_in;
                if ((match_in != '0) && (match_pkt_cnt != '1)) begin
                    match_pkt_cnt <= match_pkt_cnt + MPKT_W'(1);
                end
            end else if (w_fire) begin
                // Drop the lowest set bit, which is the one just accepted.
                r_vec <= r_vec & (r_vec - NUM_ENGINES'(1));
            end
            if ((r_state != IDLE) && w_eod && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    logic w_unused;
    assign w_unused = w_any;

endmodule
`default_nettype wire
